// File: rtl/vga_pkg.sv
// Shared VGA horizontal timing definitions used by the line-timing generator
// and the sync receiver.
package vga_pkg;

    localparam logic [9:0] VGA_HSYN    = 10'd96;
    localparam logic [9:0] VGA_HBP     = 10'd48;
    localparam logic [9:0] VGA_HACTIVE = 10'd640;
    localparam logic [9:0] VGA_HFP     = 10'd16;

    typedef enum logic [2:0] {
        HUNT,
        SYNC,
        BP,
        ACT,
        FP
    } rx_state_t;

    function automatic logic [10:0] htotal(input logic [9:0] syn,
                                           input logic [9:0] bp,
                                           input logic [9:0] act,
                                           input logic [9:0] fp);
        return 11'(syn) + 11'(bp) + 11'(act) + 11'(fp);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Normalises the sync input to active-high and flags its leading and
// trailing edges against the previous sample.
module sync_edge_det #(
    parameter logic HPOL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic hs_i,
    output logic le,
    output logic te
);

    logic a;
    logic a_q;

    assign a = HPOL ? hs_i : ~hs_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q <= 1'b0;
        end else begin
            a_q <= a;
        end
    end

    assign le = a & ~a_q;
    assign te = ~a & a_q;

endmodule

// File: rtl/h_sync_rx.sv
// Horizontal sync receiver: recovers line position from the sync leading edge,
// measures sync width and line period, and reports lock and pixel column.
module h_sync_rx
    import vga_pkg::*;
#(
    parameter logic [9:0] HSYN       = VGA_HSYN,
    parameter logic [9:0] HBP        = VGA_HBP,
    parameter logic [9:0] HACTIVE    = VGA_HACTIVE,
    parameter logic [9:0] HFP        = VGA_HFP,
    parameter logic       HPOL       = 1'b0,
    parameter logic [2:0] LOCK_LINES = 3'd4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       hs_i,
    output logic       locked_o,
    output logic       active_o,
    output logic [9:0] x_o,
    output logic       sol_o,
    output logic [9:0] width_o,
    output logic [9:0] period_o,
    output logic       err_o
);

    localparam logic [9:0] HTOTAL   = 10'(htotal(HSYN, HBP, HACTIVE, HFP));
    localparam logic [9:0] ACT_X0   = HSYN + HBP;
    localparam logic [9:0] BP_LAST  = ACT_X0 - 10'd1;
    localparam logic [9:0] ACT_LAST = ACT_X0 + HACTIVE - 10'd1;

    rx_state_t  state;
    logic [9:0] cnt;
    logic [9:0] cnt_inc;
    logic [2:0] good;
    logic [2:0] good_inc;
    logic       le;
    logic       te;

    sync_edge_det #(
        .HPOL(HPOL)
    ) u_edge (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .hs_i (hs_i),
        .le   (le),
        .te   (te)
    );

    always_comb begin
        cnt_inc  = cnt + 10'd1;
        good_inc = (good == LOCK_LINES) ? good : good + 3'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= HUNT;
            cnt      <= '0;
            good     <= '0;
            locked_o <= 1'b0;
            sol_o    <= 1'b0;
            width_o  <= '0;
            period_o <= '0;
            err_o    <= 1'b0;
        end else begin
            sol_o <= le;
            err_o <= 1'b0;

            if (le) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt_inc;
            end

            // Edge handling outranks timeout, which outranks in-line progress.
            if (le) begin
                state <= SYNC;
                if (state != HUNT) begin
                    period_o <= cnt_inc;
                    if (cnt_inc == HTOTAL) begin
                        good     <= good_inc;
                        locked_o <= (good_inc == LOCK_LINES);
                    end else begin
                        good     <= '0;
                        locked_o <= 1'b0;
                        err_o    <= 1'b1;
                    end
                end
            end else if (state != HUNT && cnt == '1) begin
                state    <= HUNT;
                good     <= '0;
                locked_o <= 1'b0;
                err_o    <= 1'b1;
            end else begin
                unique case (state)
                    SYNC: begin
                        if (te) begin
                            state   <= BP;
                            width_o <= cnt_inc;
                            if (cnt_inc != HSYN) begin
                                good     <= '0;
                                locked_o <= 1'b0;
                                err_o    <= 1'b1;
                            end
                        end
                    end
                    BP: begin
                        if (cnt >= BP_LAST) begin
                            state <= ACT;
                        end
                    end
                    ACT: begin
                        if (cnt >= ACT_LAST) begin
                            state <= FP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign active_o = (state == ACT) & locked_o;
    assign x_o      = active_o ? (cnt - ACT_X0) : '0;

endmodule

// File: tb/tb_h_sync_rx.sv
// Bench for h_sync_rx: an active-low and an active-high instance share one
// sync stream and are compared every cycle against a position-based line model.
module tb_h_sync_rx;

    localparam int HSYN    = 96;
    localparam int HBP     = 48;
    localparam int HACTIVE = 640;
    localparam int HTOTAL  = 800;
    localparam int LOCK    = 4;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic a_drv = 1'b0;
    logic hs_lo;
    logic hs_hi;

    logic       locked[2];
    logic       active[2];
    logic       sol[2];
    logic       err[2];
    logic [9:0] x[2];
    logic [9:0] width[2];
    logic [9:0] period[2];

    int checks = 0;
    int errors = 0;

    assign hs_lo = ~a_drv;
    assign hs_hi = a_drv;

    always #5 clk = ~clk;

    h_sync_rx #(
        .HPOL(1'b0)
    ) dut0 (
        .clk_i   (clk),
        .rst_i   (rst),
        .hs_i    (hs_lo),
        .locked_o(locked[0]),
        .active_o(active[0]),
        .x_o     (x[0]),
        .sol_o   (sol[0]),
        .width_o (width[0]),
        .period_o(period[0]),
        .err_o   (err[0])
    );

    h_sync_rx #(
        .HSYN      (10'd96),
        .HBP       (10'd48),
        .HACTIVE   (10'd640),
        .HFP       (10'd16),
        .HPOL      (1'b1),
        .LOCK_LINES(3'd4)
    ) dut1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .hs_i    (hs_hi),
        .locked_o(locked[1]),
        .active_o(active[1]),
        .x_o     (x[1]),
        .sol_o   (sol[1]),
        .width_o (width[1]),
        .period_o(period[1]),
        .err_o   (err[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Line model: position since the last leading edge, first trailing edge of
    // the line, and the good-line run.
    bit m_prev, m_hunt, m_locked, m_sol, m_err, m_le, m_te_ev;
    int m_pos, m_te, m_good, m_width, m_period;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_prev = 0; m_hunt = 1; m_locked = 0; m_sol = 0; m_err = 0;
            m_pos = 0; m_te = -1; m_good = 0; m_width = 0; m_period = 0;
        end else begin
            m_le    = a_drv && !m_prev;
            m_te_ev = !a_drv && m_prev;
            m_sol   = m_le;
            m_err   = 0;
            if (m_le) begin
                if (!m_hunt) begin
                    m_period = (m_pos + 1) % 1024;
                    if (m_period == HTOTAL) begin
                        if (m_good < LOCK) m_good++;
                        if (m_good == LOCK) m_locked = 1;
                    end else begin
                        m_good = 0; m_locked = 0; m_err = 1;
                    end
                end
                m_hunt = 0; m_pos = 0; m_te = -1;
            end else begin
                if (!m_hunt && m_pos == 1023) begin
                    m_hunt = 1; m_locked = 0; m_good = 0; m_err = 1;
                end else if (!m_hunt && m_te_ev && m_te < 0) begin
                    m_width = m_pos + 1;
                    m_te    = m_width;
                    if (m_width != HSYN) begin
                        m_good = 0; m_locked = 0; m_err = 1;
                    end
                end
                if (m_pos < 1023) m_pos++;
            end
            m_prev = a_drv;
        end
    end

    // Active window opens at HSYN+HBP (or just past an overlong sync) and
    // closes after the last active column.
    function automatic bit exp_active();
        int s, e;
        if (m_hunt || !m_locked || m_te < 0) return 0;
        s = (m_te + 1 > HSYN + HBP) ? m_te + 1 : HSYN + HBP;
        e = (s > HSYN + HBP + HACTIVE - 1) ? s : HSYN + HBP + HACTIVE - 1;
        return (m_pos >= s) && (m_pos <= e);
    endfunction

    int sol_seen = 0, err_seen = 0, act_run = 0, x_first = -1, x_last = -1;

    initial forever begin
        bit ea;
        @(posedge clk);
        #1;
        ea = exp_active();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("locked[%0d]", i), locked[i], m_locked);
            chk($sformatf("active[%0d]", i), active[i], ea);
            chk($sformatf("x[%0d]", i), x[i], ea ? m_pos - (HSYN + HBP) : 0);
            chk($sformatf("sol[%0d]", i), sol[i], m_sol);
            chk($sformatf("err[%0d]", i), err[i], m_err);
            chk($sformatf("width[%0d]", i), width[i], m_width);
            chk($sformatf("period[%0d]", i), period[i], m_period);
        end
        if (sol[0]) begin
            sol_seen++;
            act_run = 0;
        end
        if (err[0]) err_seen++;
        if (active[0]) begin
            if (act_run == 0) x_first = x[0];
            x_last = x[0];
            act_run++;
        end
    end

    task automatic drive_n(input bit v, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            a_drv = v;
        end
    endtask

    task automatic line(input int w, input int from, input int upto);
        for (int p = from; p < upto; p++) begin
            @(negedge clk);
            a_drv = (p < w);
        end
    endtask

    task automatic lines(input int n);
        for (int k = 0; k < n; k++) line(HSYN, 0, HTOTAL);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int s0, e0, w, per;

        rst   = 1'b1;
        a_drv = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset locked", locked[0], 0);
        chk("reset width", width[0], 0);
        chk("reset x", x[1], 0);
        rst = 1'b0;
        drive_n(0, 10);

        // Ideal lines: lock on the fourth good edge, i.e. the fifth edge overall.
        lines(LOCK);
        settle();
        chk("no lock after 4 lines", locked[0], 0);
        lines(1);
        settle();
        chk("lock after 5th edge", locked[0], 1);
        chk("width 96", width[0], 96);
        chk("period 800", period[1], 800);
        s0 = sol_seen;
        lines(1);
        settle();
        chk("active cycles/line", act_run, 640);
        chk("first x", x_first, 0);
        chk("last x", x_last, 639);
        chk("sol per line", sol_seen - s0, 1);

        // Short line.
        line(HSYN, 0, 799);
        drive_n(1, 1);
        settle();
        chk("short period", period[0], 799);
        chk("short err", err[0], 1);
        chk("short unlock", locked[0], 0);
        line(HSYN, 1, HTOTAL);
        lines(3);
        settle();
        chk("no relock yet", locked[0], 0);
        lines(1);
        settle();
        chk("relock", locked[0], 1);

        // Narrow sync.
        line(95, 0, 96);
        settle();
        chk("narrow width", width[0], 95);
        chk("narrow err", err[0], 1);
        chk("narrow unlock", locked[1], 0);
        line(95, 96, HTOTAL);
        settle();
        chk("narrow line dark", act_run, 0);
        lines(4);
        settle();
        chk("relock after narrow", locked[0], 1);

        // Stuck sync.
        e0 = err_seen;
        drive_n(1, 1100);
        settle();
        chk("timeout err count", err_seen - e0, 1);
        chk("timeout unlock", locked[0], 0);
        chk("timeout quiet active", active[0], 0);
        chk("timeout quiet sol", sol[0], 0);
        chk("timeout quiet err", err[0], 0);
        drive_n(0, 20);
        settle();
        chk("hunt ignores TE", width[0], 96);
        lines(5);
        settle();
        chk("relock after hunt", locked[0], 1);

        // Reset in the middle of the active region.
        line(HSYN, 0, 445);
        settle();
        chk("x before reset", x[0], 300);
        chk("active before reset", active[1], 1);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst locked[%0d]", i), locked[i], 0);
            chk($sformatf("rst active[%0d]", i), active[i], 0);
            chk($sformatf("rst x[%0d]", i), x[i], 0);
            chk($sformatf("rst width[%0d]", i), width[i], 0);
            chk($sformatf("rst period[%0d]", i), period[i], 0);
            chk($sformatf("rst sol[%0d]", i), sol[i], 0);
            chk($sformatf("rst err[%0d]", i), err[i], 0);
        end
        a_drv = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive_n(0, 5);
        lines(4);
        settle();
        chk("no lock after reset+4", locked[0], 0);
        lines(1);
        settle();
        chk("lock after reset+5", locked[0], 1);

        // Randomised widths and periods near nominal.
        for (int k = 0; k < 40; k++) begin
            w   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(90, 102)) : HSYN;
            per = ($urandom_range(0, 3) == 0) ? int'($urandom_range(790, 810)) : HTOTAL;
            line(w, 0, per);
        end
        drive_n(0, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
